// File: rtl/jtag_tap_ctrl_if.sv
// JTAG pin and on-chip USER register bundle for the TAP controller.
// The master side drives the JTAG pins and user_dr_in; the slave side is the TAP.
interface jtag_tap_ctrl_if #(
  parameter int unsigned IR_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 16
);
  logic                  tms;
  logic                  tdi;
  logic                  tdo;
  logic                  tdo_en;
  logic [3:0]            tap_state;
  logic [IR_WIDTH-1:0]   ir_out;
  logic [USER_WIDTH-1:0] user_dr_out;
  logic [USER_WIDTH-1:0] user_dr_in;
  logic                  user_update;

  modport master (
    output tms, tdi, user_dr_in,
    input  tdo, tdo_en, tap_state, ir_out, user_dr_out, user_update
  );

  modport slave (
    input  tms, tdi, user_dr_in,
    output tdo, tdo_en, tap_state, ir_out, user_dr_out, user_update
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register and
// BYPASS / IDCODE / USER data registers; USER value is exported to on-chip logic.
module jtag_tap_ctrl #(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter logic [31:0]          IDCODE_VAL = 32'h1000_563D,
  parameter int unsigned          USER_WIDTH = 16,
  parameter logic [USER_WIDTH-1:0] USER_RST  = '0
) (
  input  logic           tck,
  input  logic           trst,
  jtag_tap_ctrl_if.slave bus
);

  localparam int unsigned ID_WIDTH = 32;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UP_DR  = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UP_IR  = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  tap_state_e            state;
  tap_state_e            state_nxt;
  dr_sel_e               dr_sel;
  logic [IR_WIDTH-1:0]   ir_shift;
  logic [IR_WIDTH-1:0]   ir_q;
  logic                  bypass_sh;
  logic [ID_WIDTH-1:0]   idcode_sh;
  logic [USER_WIDTH-1:0] user_sh;
  logic [USER_WIDTH-1:0] user_dr_q;
  logic                  tdo_bit;
  logic                  tdo_q;
  logic                  tdo_en_q;

  // TAP transition table: next state for the sampled tms.
  function automatic tap_state_e next_state(input tap_state_e s, input logic t);
    tap_state_e n;
    n = TLR;
    unique case (s)
      TLR:    n = t ? TLR    : RTI;
      RTI:    n = t ? SEL_DR : RTI;
      SEL_DR: n = t ? SEL_IR : CAP_DR;
      CAP_DR: n = t ? EX1_DR : SH_DR;
      SH_DR:  n = t ? EX1_DR : SH_DR;
      EX1_DR: n = t ? UP_DR  : PAU_DR;
      PAU_DR: n = t ? EX2_DR : PAU_DR;
      EX2_DR: n = t ? UP_DR  : SH_DR;
      UP_DR:  n = t ? SEL_DR : RTI;
      SEL_IR: n = t ? TLR    : CAP_IR;
      CAP_IR: n = t ? EX1_IR : SH_IR;
      SH_IR:  n = t ? EX1_IR : SH_IR;
      EX1_IR: n = t ? UP_IR  : PAU_IR;
      PAU_IR: n = t ? EX2_IR : PAU_IR;
      EX2_IR: n = t ? UP_IR  : SH_IR;
      UP_IR:  n = t ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  // Right shift with tdi entering the MSB; safe for a 1-bit register.
  function automatic logic [USER_WIDTH-1:0] shift_user(input logic [USER_WIDTH-1:0] v,
                                                       input logic b);
    logic [USER_WIDTH-1:0] r;
    r = v >> 1;
    r[USER_WIDTH-1] = b;
    return r;
  endfunction

  assign state_nxt = next_state(state, bus.tms);

  // Unknown instruction codes fall back to BYPASS.
  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == IR_IDCODE) begin
      dr_sel = SEL_IDCODE;
    end else if (ir_q == IR_USER) begin
      dr_sel = SEL_USER;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state <= TLR;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction register; TLR entry reloads IDCODE just like trst.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_shift <= '0;
      ir_q     <= IR_IDCODE;
    end else begin
      unique case (state)
        CAP_IR:  ir_shift <= IR_CAPTURE;
        SH_IR:   ir_shift <= {bus.tdi, ir_shift[IR_WIDTH-1:1]};
        default: ir_shift <= ir_shift;
      endcase
      if (state_nxt == TLR) begin
        ir_q <= IR_IDCODE;
      end else if (state == UP_IR) begin
        ir_q <= ir_shift;
      end
    end
  end

  // Data registers: only the register selected by the instruction captures or shifts.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      bypass_sh <= 1'b0;
      idcode_sh <= '0;
      user_sh   <= '0;
    end else if (state == CAP_DR) begin
      unique case (dr_sel)
        SEL_IDCODE: idcode_sh <= IDCODE_VAL;
        SEL_USER:   user_sh   <= bus.user_dr_in;
        default:    bypass_sh <= 1'b0;
      endcase
    end else if (state == SH_DR) begin
      unique case (dr_sel)
        SEL_IDCODE: idcode_sh <= {bus.tdi, idcode_sh[ID_WIDTH-1:1]};
        SEL_USER:   user_sh   <= shift_user(user_sh, bus.tdi);
        default:    bypass_sh <= bus.tdi;
      endcase
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      user_dr_q <= USER_RST;
    end else if ((state == UP_DR) && (dr_sel == SEL_USER)) begin
      user_dr_q <= user_sh;
    end
  end

  always_comb begin
    tdo_bit = 1'b0;
    if (state == SH_IR) begin
      tdo_bit = ir_shift[0];
    end else if (state == SH_DR) begin
      unique case (dr_sel)
        SEL_IDCODE: tdo_bit = idcode_sh[0];
        SEL_USER:   tdo_bit = user_sh[0];
        default:    tdo_bit = bypass_sh;
      endcase
    end
  end

  // tdo/tdo_en change on the falling edge so the driver samples a stable bit.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_bit;
      tdo_en_q <= (state == SH_DR) || (state == SH_IR);
    end
  end

  assign bus.tdo         = tdo_q;
  assign bus.tdo_en      = tdo_en_q;
  assign bus.tap_state   = state;
  assign bus.ir_out      = ir_q;
  assign bus.user_dr_out = user_dr_q;
  assign bus.user_update = (state == UP_DR) && (dr_sel == SEL_USER);

endmodule
